cpu_mem_loader: RTL
===================

// Module: cpu_mem_loader
// PURPOSE
//  Host-side initiator for the cpu external memory ports. It takes a 32-bit command/data stream
//  and writes instruction memory and data memory through the *_ext/*_ext_2 ports. It also reads
//  data memory back onto a 32-bit output stream and gates the cpu enable input for program runs.
//  It sits beside cpu in the top level and is the only driver of the ext ports and enable.
// PARAMETERS
//  IMEM_IDX_W  7   word-index bits of IMEM (32-bit words; byte addr = idx<<2)
//  DMEM_IDX_W  7   word-index bits of DMEM (64-bit words; byte addr = idx<<3)
//  CNT_W       14  width of header count field (fixed by header format; do not change)
// PORTS
//  clk          in   1   clock
//  arst_n       in   1   asynchronous reset, active low
//  s_valid      in   1   input stream word valid
//  s_data       in   32  input stream word (header or payload)
//  s_ready      out  1   loader accepts s_data this cycle
//  m_valid      out  1   readback word valid
//  m_data       out  32  readback word
//  m_ready      in   1   sink accepts m_data
//  cpu_enable   out  1   drives cpu enable
//  addr_ext     out  64  IMEM byte address
//  wen_ext      out  1   IMEM write strobe
//  ren_ext      out  1   IMEM read enable (tied 0)
//  wdata_ext    out  32  IMEM write word
//  addr_ext_2   out  64  DMEM byte address
//  wen_ext_2    out  1   DMEM write strobe
//  ren_ext_2    out  1   DMEM read enable
//  wdata_ext_2  out  64  DMEM write word
//  rdata_ext_2  in   64  DMEM read word, valid 1 cycle after ren_ext_2
//  busy         out  1   state != IDLE
//  run_done     out  1   1-cycle pulse at end of RUN
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, index/count/buffers 0. Reset mid-op abandons the command; no strobe follows.
//  Handshake: transfer when valid&ready. m_data is stable while m_valid=1 and m_ready=0.
//  Header (accepted in IDLE): [31:30] cmd 00=WR_IMEM 01=WR_DMEM 10=RD_DMEM 11=RUN;
//    [29:16] count (words or cycles); [15:0] start word idx, truncated to *_IDX_W bits.
//  States: IDLE, WR_I, WR_D_LO, WR_D_HI, RD_REQ, RD_WAIT, RD_LO, RD_HI, RUN.
//  s_ready=1 only in IDLE, WR_I, WR_D_LO, WR_D_HI; stream throughput is 1 word/cycle.
//  count=0: stay IDLE and issue no strobes; for RUN, still pulse run_done the next cycle.
//  WR_I: each accepted word -> next cycle wen_ext=1 for 1 cycle, addr_ext={0,idx,2'b00}, wdata_ext=word.
//    Then idx++ and count--; on the last word go to IDLE (its strobe lands during IDLE).
//  WR_D_LO: latch low half -> WR_D_HI. WR_D_HI: accept high half -> next cycle wen_ext_2=1,
//    addr_ext_2={0,idx,3'b000}, wdata_ext_2={hi,lo}. Then idx++, count--, next LO or IDLE.
//  RD_REQ: ren_ext_2=1 for 1 cycle with addr_ext_2 -> RD_WAIT captures rdata_ext_2 -> RD_LO.
//    RD_LO: m_valid, m_data=buf[31:0]; on accept -> RD_HI with m_data=buf[63:32].
//    On accept: count-- then RD_REQ (idx++) or IDLE.
//  Index wraps modulo 2^*_IDX_W (e.g. IMEM idx 127 -> 0). Upper address bits are always 0.
//  RUN: cpu_enable=1 for exactly count cycles starting the cycle after header accept.
//    run_done pulses the cycle after cpu_enable falls. No ext strobe is active while cpu_enable=1.
//  Strobes are 1-cycle pulses. wen_ext, wen_ext_2 and ren_ext_2 are never high together.
//  ren_ext is constantly 0.
// TESTING
//  1 hdr 0x0003_0000 + words A,B,C -> wen_ext pulses 3x, addr 0x0,0x4,0x8, wdata A,B,C.
//  2 hdr 0x4001_0002 + 0xDEADBEEF, 0x01234567 -> one wen_ext_2, addr 0x10, wdata 0x01234567DEADBEEF.
//  3 hdr 0x8001_0002, m_ready toggling 0/1 -> m_data 0xDEADBEEF then 0x01234567,
//    each held stable until its handshake.
//  4 hdr 0xC005_0000 -> cpu_enable high exactly 5 cycles, run_done 1 pulse, ext strobes 0 throughout.
//  5 hdr 0x0002_007F + 2 words -> addr_ext 0x1FC then 0x000 (wrap).
//  6 WR_DMEM, assert arst_n=0 after LO half accepted -> no wen_ext_2, outputs 0,
//    state IDLE, busy=0 after release.

Source files
------------

// File: rtl/cpu_mem_loader_if.sv
// Bus bundle between the host-side loader and the rest of the top level:
// input command stream, readback stream, cpu enable and both ext memory ports.
interface cpu_mem_loader_if;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;
    logic        cpu_enable;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2;
    logic        busy;
    logic        run_done;

    // Loader side: drives the memory ports, enable and both stream handshakes it owns.
    modport master (
        input  s_valid, s_data, m_ready, rdata_ext_2,
        output s_ready, m_valid, m_data, cpu_enable,
               addr_ext, wen_ext, ren_ext, wdata_ext,
               addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
               busy, run_done
    );

    // Host / memory side.
    modport slave (
        output s_valid, s_data, m_ready, rdata_ext_2,
        input  s_ready, m_valid, m_data, cpu_enable,
               addr_ext, wen_ext, ren_ext, wdata_ext,
               addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
               busy, run_done
    );
endinterface

// File: rtl/cpu_mem_loader.sv
// Host-side initiator for the cpu ext memory ports. Decodes a header word,
// then streams payload into IMEM/DMEM, reads DMEM back as two 32-bit words per
// 64-bit entry, or enables the cpu for a fixed number of cycles.
// All ext strobes are registered, so each lands the cycle after its stream beat.
module cpu_mem_loader #(
    parameter int IMEM_IDX_W = 7,
    parameter int DMEM_IDX_W = 7,
    parameter int CNT_W      = 14
) (
    input logic               clk,
    input logic               arst_n,
    cpu_mem_loader_if.master  bus
);
    localparam int IDX_W = (IMEM_IDX_W > DMEM_IDX_W) ? IMEM_IDX_W : DMEM_IDX_W;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_I, S_WR_D_LO, S_WR_D_HI, S_RD_REQ, S_RD_WAIT, S_RD_LO, S_RD_HI, S_RUN
    } state_t;

    localparam logic [1:0] CMD_WR_IMEM = 2'b00;
    localparam logic [1:0] CMD_WR_DMEM = 2'b01;
    localparam logic [1:0] CMD_RD_DMEM = 2'b10;
    localparam logic [1:0] CMD_RUN     = 2'b11;

    state_t             state_q, state_d;
    logic               rdy_q;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        lo_q, lo_d;
    logic [63:0]        buf_q, buf_d;
    logic               wen_q, wen_d;
    logic [63:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               wen2_q, wen2_d;
    logic               ren2_q, ren2_d;
    logic [63:0]        addr2_q, addr2_d;
    logic [63:0]        wdata2_q, wdata2_d;
    logic               run_done_q, run_done_d;

    logic               hs_in, hs_out, last;
    logic [1:0]         hdr_cmd;
    logic [CNT_W-1:0]   hdr_cnt;
    logic [IDX_W-1:0]   hdr_idx, idx_i_nxt, idx_d_nxt;

    function automatic logic [63:0] imem_addr(input logic [IDX_W-1:0] i);
        return {{(62-IMEM_IDX_W){1'b0}}, i[IMEM_IDX_W-1:0], 2'b00};
    endfunction

    function automatic logic [63:0] dmem_addr(input logic [IDX_W-1:0] i);
        return {{(61-DMEM_IDX_W){1'b0}}, i[DMEM_IDX_W-1:0], 3'b000};
    endfunction

    assign hdr_cmd   = bus.s_data[31:30];
    assign hdr_cnt   = bus.s_data[29:16];
    assign hdr_idx   = IDX_W'(bus.s_data[15:0]);
    // Each memory wraps at its own depth.
    assign idx_i_nxt = IDX_W'(IMEM_IDX_W'(idx_q[IMEM_IDX_W-1:0] + 1'b1));
    assign idx_d_nxt = IDX_W'(DMEM_IDX_W'(idx_q[DMEM_IDX_W-1:0] + 1'b1));
    assign hs_in     = bus.s_valid & bus.s_ready;
    assign hs_out    = bus.m_valid & bus.m_ready;
    assign last      = (cnt_q == CNT_W'(1));

    // State and datapath registers; reset abandons any command in flight.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_IDLE;
            rdy_q      <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            lo_q       <= '0;
            buf_q      <= '0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wen2_q     <= 1'b0;
            ren2_q     <= 1'b0;
            addr2_q    <= '0;
            wdata2_q   <= '0;
            run_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= 1'b1;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            lo_q       <= lo_d;
            buf_q      <= buf_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wen2_q     <= wen2_d;
            ren2_q     <= ren2_d;
            addr2_q    <= addr2_d;
            wdata2_q   <= wdata2_d;
            run_done_q <= run_done_d;
        end
    end

    // Next-state: a zero-count header never leaves IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (hs_in && hdr_cnt != '0) begin
                case (hdr_cmd)
                    CMD_WR_IMEM: state_d = S_WR_I;
                    CMD_WR_DMEM: state_d = S_WR_D_LO;
                    CMD_RD_DMEM: state_d = S_RD_REQ;
                    default:     state_d = S_RUN;
                endcase
            end
            S_WR_I:    if (hs_in && last) state_d = S_IDLE;
            S_WR_D_LO: if (hs_in) state_d = S_WR_D_HI;
            S_WR_D_HI: if (hs_in) state_d = last ? S_IDLE : S_WR_D_LO;
            S_RD_REQ:  state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = S_RD_LO;
            S_RD_LO:   if (hs_out) state_d = S_RD_HI;
            S_RD_HI:   if (hs_out) state_d = last ? S_IDLE : S_RD_REQ;
            S_RUN:     if (last) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath and strobe updates; strobes default low so each is a single-cycle pulse.
    always_comb begin
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        lo_d       = lo_q;
        buf_d      = buf_q;
        wen_d      = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wen2_d     = 1'b0;
        ren2_d     = 1'b0;
        addr2_d    = addr2_q;
        wdata2_d   = wdata2_q;
        run_done_d = 1'b0;
        case (state_q)
            S_IDLE: if (hs_in) begin
                cnt_d = hdr_cnt;
                idx_d = hdr_idx;
                if (hdr_cmd == CMD_RD_DMEM && hdr_cnt != '0) begin
                    ren2_d  = 1'b1;
                    addr2_d = dmem_addr(hdr_idx);
                end
                if (hdr_cmd == CMD_RUN && hdr_cnt == '0) run_done_d = 1'b1;
            end
            S_WR_I: if (hs_in) begin
                wen_d   = 1'b1;
                addr_d  = imem_addr(idx_q);
                wdata_d = bus.s_data;
                idx_d   = idx_i_nxt;
                cnt_d   = cnt_q - 1'b1;
            end
            S_WR_D_LO: if (hs_in) lo_d = bus.s_data;
            S_WR_D_HI: if (hs_in) begin
                wen2_d   = 1'b1;
                addr2_d  = dmem_addr(idx_q);
                wdata2_d = {bus.s_data, lo_q};
                idx_d    = idx_d_nxt;
                cnt_d    = cnt_q - 1'b1;
            end
            S_RD_WAIT: buf_d = bus.rdata_ext_2;
            S_RD_HI: if (hs_out) begin
                cnt_d = cnt_q - 1'b1;
                if (!last) begin
                    idx_d   = idx_d_nxt;
                    ren2_d  = 1'b1;
                    addr2_d = dmem_addr(idx_d_nxt);
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (last) run_done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Output decode; s_ready is held low until the first clock after reset.
    always_comb begin
        bus.s_ready     = rdy_q && (state_q == S_IDLE || state_q == S_WR_I ||
                                    state_q == S_WR_D_LO || state_q == S_WR_D_HI);
        bus.m_valid     = (state_q == S_RD_LO) || (state_q == S_RD_HI);
        bus.m_data      = (state_q == S_RD_HI) ? buf_q[63:32] : buf_q[31:0];
        bus.cpu_enable  = (state_q == S_RUN);
        bus.addr_ext    = addr_q;
        bus.wen_ext     = wen_q;
        bus.ren_ext     = 1'b0;
        bus.wdata_ext   = wdata_q;
        bus.addr_ext_2  = addr2_q;
        bus.wen_ext_2   = wen2_q;
        bus.ren_ext_2   = ren2_q;
        bus.wdata_ext_2 = wdata2_q;
        bus.busy        = (state_q != S_IDLE);
        bus.run_done    = run_done_q;
    end
endmodule
